fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the RISC-V CPU. Owns the program counter, drives the synchronous-read instruction memory, and delivers each fetched instruction and its PC through a registered F/D boundary to the decode stage, where the immediate generator, register file and control decoder consume it. Handles decode stalls, execute-stage redirects (branch, jal, jalr) and the post-reset boot bubble.

## Interface
- RESET_PC, 32'h0000_0000: PC of the first instruction fetched after reset.
- IMEM_AW, 12: instruction memory word-address width.
- NOP, 32'h0000_0013: instruction (addi x0,x0,0) presented to decode during bubbles.

- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous and active-high.
- stall  input  1  decode cannot accept; hold F/D contents and PC.
- redirect_valid  input  1  execute resolved a taken branch/jump.
- redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 0).
- imem_en  output  1  memory read enable; equals !rst.
- imem_addr  output  IMEM_AW  combinational word address; data on imem_dout one cycle later.
- imem_dout  input  32  memory read data.
- inst_out  output  32  F/D instruction register.
- pc_out  output  32  F/D PC register.
- inst_valid  output  1  inst_out is a real instruction (0 = bubble).
- fetch_count  output  32  instructions delivered to decode since reset, wraps.

## Operation
- Internal state: pc_f (PC whose data is on imem_dout this cycle), state BOOT/RUN, F/D registers, fetch_count.
- Reset: pc_f=RESET_PC, state=BOOT, inst_out=NOP, pc_out=0, inst_valid=0, fetch_count=0. imem_en=0 while rst high.
- Per-cycle priority: rst > redirect_valid > stall > state behaviour.
- Redirect (any state, stall ignored): imem_addr=redirect_pc[IMEM_AW+1:2]; pc_f<={redirect_pc[31:2],2'b00}; state<=RUN; F/D <= {NOP, 0, valid 0} (kills the wrong-path instruction currently on imem_dout); fetch_count unchanged.
- Stall (no redirect): imem_addr=pc_f[IMEM_AW+1:2] (reissue same word so imem_dout stays correct); pc_f and F/D held; BOOT still advances to RUN.
- BOOT, no stall/redirect: imem_addr=pc_f; state<=RUN; F/D <= bubble.
- RUN, no stall/redirect: F/D <= {imem_dout, pc_f, 1}; fetch_count+=1; pc_f<=pc_f+4; imem_addr=(pc_f+4)[IMEM_AW+1:2].
- Arithmetic: pc_f+4 is modulo 2^32; imem_addr truncation wraps modulo 2^IMEM_AW words. fetch_count wraps 0xFFFF_FFFF→0.
- Reset mid-operation: next edge returns every register to reset values regardless of stall/redirect.

## Timing
- imem_addr is combinational from pc_f, state, stall, redirect_valid, redirect_pc; memory has 1-cycle read latency.
- Reset release: rst low in cycle 0 (BOOT, addr RESET_PC); first valid inst_out/pc_out=RESET_PC visible in cycle 2.
- Redirect asserted in cycle t: inst_valid=0 in cycle t+1; target instruction on inst_out in cycle t+2.
- Stall: outputs change no earlier than the edge after stall deasserts; no instruction lost or duplicated.
- Steady state, no stalls: one instruction per cycle, pc_out increments by 4.

## Test plan
- Reset, memory word i = 0x0000_0000+i, no stall: cycle 2 inst_out=0x0, pc_out=0x0, valid=1; cycles 3,4 pc_out=0x4,0x8; fetch_count=3 in cycle 4.
- Stall high cycles 5-7 in steady stream: inst_out/pc_out frozen at cycle-5 values, fetch_count frozen; after release, next pc_out = previous+4, no gap or duplicate.
- redirect_valid with redirect_pc=0x0000_0103 in cycle 10: cycle 11 inst_out=0x13, valid=0; cycle 12 pc_out=0x100, inst_out=mem[0x40]; fetch_count unchanged across bubble.
- Redirect and stall asserted together: redirect wins; same response as previous scenario.
- Redirect to 0x0000_3FFC (last word, IMEM_AW=12): pc_out 0x3FFC then 0x4000 with imem_addr wrapped to 0, inst_out=mem[0].
- rst asserted for one cycle mid-stream during stall: next cycle inst_valid=0, inst_out=0x13, fetch_count=0, then restart at RESET_PC two cycles after release.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the synchronous-read instruction
// memory and registers each fetched instruction and its PC at the F/D boundary.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 12,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_dout,
    output logic [31:0]        inst_out,
    output logic [31:0]        pc_out,
    output logic               inst_valid,
    output logic [31:0]        fetch_count
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t      state, state_next;
    logic [31:0] pc_f;
    logic [31:0] pc_seq;
    logic [31:0] redirect_aligned;

    assign pc_seq           = pc_f + 32'd4;
    assign redirect_aligned = redirect_pc & ~32'h3;
    assign imem_en          = !rst;

    // imem_addr always names the word whose data must be on imem_dout next
    // cycle, which is the PC that pc_f will hold after this edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        imem_addr  = pc_f[IMEM_AW+1:2];
        state_next = state;
        if (redirect_valid) begin
            imem_addr  = redirect_pc[IMEM_AW+1:2];
            state_next = RUN;
        end else if (stall) begin
            state_next = RUN;
        end else if (state == BOOT) begin
            state_next = RUN;
        end else begin
            imem_addr = pc_seq[IMEM_AW+1:2];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc_f        <= RESET_PC;
            inst_out    <= NOP;
            pc_out      <= 32'd0;
            inst_valid  <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                // The word on imem_dout this cycle is wrong-path: replace it with a bubble.
                pc_f       <= redirect_aligned;
                inst_out   <= NOP;
                pc_out     <= 32'd0;
                inst_valid <= 1'b0;
            end else if (!stall) begin
                if (state == BOOT) begin
                    inst_out   <= NOP;
                    pc_out     <= 32'd0;
                    inst_valid <= 1'b0;
                end else begin
                    inst_out    <= imem_dout;
                    pc_out      <= pc_f;
                    inst_valid  <= 1'b1;
                    fetch_count <= fetch_count + 32'd1;
                    pc_f        <= pc_seq;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/redirect/reset traffic, compared against a PC-stream reference model.
module tb_fetch_stage;

    localparam int          AW  = 12;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst, stall, redirect_valid;
    logic [31:0]   redirect_pc;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_dout;
    logic [31:0]   inst_out, pc_out, fetch_count;
    logic          inst_valid;

    logic [31:0] mem [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;

    // Reference model: what decode should see, expressed as an instruction stream.
    logic [31:0] m_inst, m_pc, m_count, m_next;
    logic        m_valid, m_warm, m_known;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(AW), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_dout(imem_dout),
        .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (imem_en) imem_dout <= mem[imem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return mem[(pc >> 2) % (1 << AW)];
    endfunction

    // One cycle: drive inputs, check combinational memory port, clock, check F/D.
    task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic st);
        logic [31:0] exp_word_pc;
        @(negedge clk);
        rst = r; redirect_valid = rv; redirect_pc = rpc; stall = st;
        #1;
        check("imem_en", {31'd0, imem_en}, {31'd0, !r});
        if (!r && m_known) begin
            if (rv)                 exp_word_pc = rpc;
            else if (st || !m_warm) exp_word_pc = m_next;
            else                    exp_word_pc = m_next + 32'd4;
            check("imem_addr", {20'd0, imem_addr}, {20'd0, exp_word_pc[AW+1:2]});
        end
        @(posedge clk);
        if (r) begin
            m_known = 1'b1; m_next = 32'h0; m_warm = 1'b0;
            m_inst = NOP; m_pc = 32'h0; m_valid = 1'b0; m_count = 32'h0;
        end else if (rv) begin
            m_next = {rpc[31:2], 2'b00}; m_warm = 1'b1;
            m_inst = NOP; m_pc = 32'h0; m_valid = 1'b0;
        end else if (st) begin
            m_warm = 1'b1;
        end else if (!m_warm) begin
            m_warm = 1'b1;
            m_inst = NOP; m_pc = 32'h0; m_valid = 1'b0;
        end else begin
            m_inst = word_at(m_next); m_pc = m_next; m_valid = 1'b1;
            m_count = m_count + 32'd1; m_next = m_next + 32'd4;
        end
        #1;
        if (m_known) begin
            check("inst_out", inst_out, m_inst);
            check("pc_out", pc_out, m_pc);
            check("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
            check("fetch_count", fetch_count, m_count);
        end
    endtask

    initial begin
        logic [31:0] frozen_pc;
        logic [31:0] rpc;
        for (int i = 0; i < (1 << AW); i++) mem[i] = i;
        m_known = 1'b0; m_warm = 1'b0; m_next = 32'h0;
        m_inst = NOP; m_pc = 32'h0; m_valid = 1'b0; m_count = 32'h0;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("reset_inst", inst_out, NOP);
        check("reset_count", fetch_count, 32'd0);

        step(0, 0, 0, 0);                       // cycle 0 -> cycle 1: bubble
        check("boot_bubble", {31'd0, inst_valid}, 32'd0);
        step(0, 0, 0, 0);                       // cycle 2
        check("first_pc", pc_out, 32'h0);
        check("first_valid", {31'd0, inst_valid}, 32'd1);
        step(0, 0, 0, 0);                       // cycle 3
        check("second_pc", pc_out, 32'h4);
        step(0, 0, 0, 0);                       // cycle 4
        check("third_pc", pc_out, 32'h8);
        check("count_3", fetch_count, 32'd3);

        frozen_pc = pc_out;
        repeat (3) step(0, 0, 0, 1);
        check("stall_frozen_pc", pc_out, frozen_pc);
        check("stall_frozen_count", fetch_count, 32'd3);
        step(0, 0, 0, 0);
        check("stall_release_pc", pc_out, frozen_pc + 32'd4);
        check("stall_release_inst", inst_out, (frozen_pc + 32'd4) >> 2);
        step(0, 0, 0, 0);

        step(0, 1, 32'h0000_0103, 0);
        check("redir_bubble_inst", inst_out, NOP);
        check("redir_bubble_valid", {31'd0, inst_valid}, 32'd0);
        step(0, 0, 0, 0);
        check("redir_target_pc", pc_out, 32'h100);
        check("redir_target_inst", inst_out, 32'h40);
        check("redir_count", fetch_count, 32'd6);

        step(0, 1, 32'h0000_0103, 1);
        check("redir_stall_valid", {31'd0, inst_valid}, 32'd0);
        step(0, 0, 0, 0);
        check("redir_stall_pc", pc_out, 32'h100);

        step(0, 1, 32'h0000_3FFC, 0);
        step(0, 0, 0, 0);
        check("last_word_pc", pc_out, 32'h3FFC);
        check("last_word_inst", inst_out, 32'hFFF);
        step(0, 0, 0, 0);
        check("wrap_pc", pc_out, 32'h4000);
        check("wrap_inst", inst_out, 32'h0);

        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        check("midreset_valid", {31'd0, inst_valid}, 32'd0);
        check("midreset_inst", inst_out, NOP);
        check("midreset_count", fetch_count, 32'd0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("restart_pc", pc_out, 32'h0);
        check("restart_valid", {31'd0, inst_valid}, 32'd1);

        for (int n = 0; n < 3000; n++) begin
            rpc = $urandom;
            if ($urandom_range(0, 1) == 0) rpc = rpc & 32'h0000_FFFF;
            step($urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0, rpc,
                 $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
